// File: rtl/control_store_seq.sv
// Writable microcode control store: registered lookup with valid/ready handshakes and multi-cycle hold.
// Optional CS_PARITY_EN adds a per-entry even-parity bit and a parity_err output.
module control_store_seq #(
  parameter int ADDR_W = 6,
  parameter int CW_W   = 13,
  parameter int MC_LAT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] mapped_address,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   ctrl_word,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CW_W-1:0]   wr_data,
`ifdef CS_PARITY_EN
  input  logic              wr_mc,
  output logic              parity_err
`else
  input  logic              wr_mc
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(MC_LAT + 1);
  localparam logic [CNT_W-1:0] MC_LAT_C = CNT_W'(MC_LAT);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  // RV32 base+M decode table; only meaningful for the 13-bit control word layout.
  function automatic logic [CW_W-1:0] default_cw(input int idx);
    logic [12:0] w;
    case (idx)
      1:  w = 13'h1050;  2:  w = 13'h10D0;  3:  w = 13'h1010;  4:  w = 13'h1030;
      5:  w = 13'h1070;  6:  w = 13'h1090;  7:  w = 13'h10B0;  8:  w = 13'h10F0;
      9:  w = 13'h1110;  10: w = 13'h1048;  11: w = 13'h1C58;  12: w = 13'h0258;
      13: w = 13'h00D2;  14: w = 13'h0132;  15: w = 13'h0112;  16: w = 13'h0172;
      17: w = 13'h1008;  18: w = 13'h1028;  19: w = 13'h1068;  20: w = 13'h1088;
      21: w = 13'h10A8;  22: w = 13'h10E8;  23: w = 13'h1108;  24: w = 13'h11E8;
      25: w = 13'h104D;  26: w = 13'h1055;  27: w = 13'h1150;  28: w = 13'h11B0;
      29: w = 13'h11D0;
      default: w = 13'h0000;
    endcase
    if (CW_W != 13) return '0;
    return CW_W'(w);
  endfunction

  function automatic logic default_mc(input int idx);
    return (CW_W == 13) && (idx >= 27) && (idx <= 29);
  endfunction

  logic [CW_W-1:0]  cw_q [DEPTH];
  logic             mc_q [DEPTH];
  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CW_W-1:0]  ctrl_q, ctrl_d;
  logic             launch;
  logic [CW_W-1:0]  rd_cw;
  logic             rd_mc;

  assign rd_cw = cw_q[mapped_address];
  assign rd_mc = mc_q[mapped_address];

  // Lookups read the pre-edge contents, giving read-before-write on address collisions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        cw_q[i] <= default_cw(i);
        mc_q[i] <= default_mc(i);
      end
    end else if (wr_en) begin
      cw_q[wr_addr] <= wr_data;
      mc_q[wr_addr] <= wr_mc;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ctrl_d   = ctrl_q;
    launch   = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        launch   = in_valid;
      end
      S_WAIT: begin
        count_d = count_q - ONE_C;
        if (count_q == ONE_C) state_d = S_HOLD;
      end
      S_HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) launch = 1'b1;
          else          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (launch) begin
      ctrl_d = rd_cw;
      if (rd_mc) begin
        state_d = S_WAIT;
        count_d = MC_LAT_C;
      end else begin
        state_d = S_HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q == S_WAIT);
  assign ctrl_word = ctrl_q;

`ifdef CS_PARITY_EN
  logic par_q [DEPTH];
  logic perr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) par_q[i] <= ^default_cw(i);
    end else if (wr_en) begin
      par_q[wr_addr] <= ^wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    perr_q <= 1'b0;
    else if (launch) perr_q <= ^{rd_cw, par_q[mapped_address]};
  end

  assign parity_err = perr_q & out_valid;
`endif

endmodule
